// File: rtl/msrv32_fetch_unit.sv
// MSRV32 instruction-fetch stage: owns the PC, issues one imem request at a time,
// and applies trap/mret/branch redirects with misaligned-target detection.
//
// state    | meaning
// IDLE     | just out of reset, first fetch issued next cycle
// REQ      | request outstanding at fetch_addr
// KILL     | request outstanding but already redirected; data will be dropped
// VALID    | instruction held for decode, no request
// MISALIGN | redirect target misaligned; waiting for a trap
module msrv32_fetch_unit #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_address_in,
  input  logic        mret_in,
  input  logic [31:0] epc_in,
  input  logic        stall_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid_out,
  output logic        misaligned_instr_out
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    KILL     = 3'd2,
    VALID    = 3'd3,
    MISALIGN = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] pending_q, pending_d;
  logic        pending_mis_q, pending_mis_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic        req_q, req_d;

  logic        redir;
  logic [31:0] tgt;
  logic        tgt_mis;
  logic [31:0] kill_tgt;
  logic        kill_mis;

  // Trap > mret > branch; misalignment is judged on bit1 after bit0 is dropped.
  always_comb begin
    redir = trap_taken_in | mret_in | branch_taken_in;
    if (trap_taken_in)  tgt = {trap_address_in[31:2], 2'b00};
    else if (mret_in)   tgt = epc_in;
    else                tgt = {branch_target_in[31:1], 1'b0};
    tgt_mis  = tgt[1];
    kill_tgt = redir ? tgt : pending_q;
    kill_mis = redir ? tgt_mis : pending_mis_q;
  end

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    pending_d     = pending_q;
    pending_mis_d = pending_mis_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    valid_d       = valid_q;
    mis_d         = mis_q;

    case (state_q)
      IDLE: begin
        state_d      = REQ;
        fetch_addr_d = BOOT_ADDRESS;
      end
      REQ: begin
        if (imem_ack_in) begin
          if (redir) begin
            if (tgt_mis) begin
              state_d = MISALIGN;
              pc_d    = tgt;
              mis_d   = 1'b1;
            end else begin
              fetch_addr_d = tgt;
            end
          end else begin
            instr_d = imem_rdata_in;
            pc_d    = fetch_addr_q;
            valid_d = 1'b1;
            state_d = VALID;
          end
        end else if (redir) begin
          pending_d     = tgt;
          pending_mis_d = tgt_mis;
          state_d       = KILL;
        end
      end
      KILL: begin
        if (imem_ack_in) begin
          if (kill_mis) begin
            state_d = MISALIGN;
            pc_d    = kill_tgt;
            mis_d   = 1'b1;
          end else begin
            state_d      = REQ;
            fetch_addr_d = kill_tgt;
          end
        end else if (redir) begin
          pending_d     = tgt;
          pending_mis_d = tgt_mis;
        end
      end
      VALID: begin
        if (redir) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (tgt_mis) begin
            state_d = MISALIGN;
            pc_d    = tgt;
            mis_d   = 1'b1;
          end else begin
            state_d      = REQ;
            fetch_addr_d = tgt;
          end
        end else if (!stall_in) begin
          valid_d      = 1'b0;
          instr_d      = NOP_INSTR;
          fetch_addr_d = pc_q + 32'd4;
          state_d      = REQ;
        end
      end
      MISALIGN: begin
        if (trap_taken_in) begin
          mis_d        = 1'b0;
          fetch_addr_d = {trap_address_in[31:2], 2'b00};
          state_d      = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_d = (state_d == REQ) || (state_d == KILL);
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q       <= IDLE;
      fetch_addr_q  <= BOOT_ADDRESS;
      pending_q     <= BOOT_ADDRESS;
      pending_mis_q <= 1'b0;
      pc_q          <= BOOT_ADDRESS;
      instr_q       <= NOP_INSTR;
      valid_q       <= 1'b0;
      mis_q         <= 1'b0;
      req_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      pending_q     <= pending_d;
      pending_mis_q <= pending_mis_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      valid_q       <= valid_d;
      mis_q         <= mis_d;
      req_q         <= req_d;
    end
  end

  assign imem_req_out         = req_q;
  assign imem_addr_out        = fetch_addr_q;
  assign pc_out               = pc_q;
  assign instr_out            = instr_q;
  assign instr_valid_out      = valid_q;
  assign misaligned_instr_out = mis_q;

endmodule

// File: doc/msrv32_fetch_unit.md
Name: msrv32_fetch_unit

Overview:
Instruction-fetch stage of the MSRV32 processor. It owns the program counter and issues one instruction-memory request at a time with a req/ack handshake. It presents the fetched instruction and its PC to decode. It consumes the redirect produced downstream (branch_taken from the branch unit, plus trap/mret from the CSR unit) and computes the next PC.

Parameters:
BOOT_ADDRESS, 32'h0000_0000, PC loaded at reset and first fetch address
NOP_INSTR, 32'h0000_0013, value driven on instr_out while no valid instruction (ADDI x0,x0,0)

Ports:
ms_riscv32_mp_clk_in  input  1  clock, rising edge
ms_riscv32_mp_rst_n_in  input  1  reset, asynchronous, active-low
branch_taken_in  input  1  redirect from branch unit (JAL/JALR/taken B-type)
branch_target_in  input  32  redirect target from immediate adder
trap_taken_in  input  1  trap redirect from CSR unit
trap_address_in  input  32  trap vector (mtvec)
mret_in  input  1  return-from-trap redirect
epc_in  input  32  mret target (mepc)
stall_in  input  1  decode cannot accept; hold current instruction
imem_req_out  output  1  instruction-memory request
imem_addr_out  output  32  fetch address, stable while imem_req_out=1
imem_ack_in  input  1  memory ack; imem_rdata_in valid this cycle
imem_rdata_in  input  32  fetched instruction word
pc_out  output  32  PC of instr_out (or faulting target in MISALIGN)
instr_out  output  32  held instruction
instr_valid_out  output  1  instr_out/pc_out valid for decode
misaligned_instr_out  output  1  redirect target not 4-byte aligned

Behaviour:
- Reset is asynchronous and active-low. While ms_riscv32_mp_rst_n_in=0: state=IDLE, fetch_addr=BOOT_ADDRESS, pc_out=BOOT_ADDRESS, instr_out=NOP_INSTR, instr_valid_out=0, imem_req_out=0, misaligned_instr_out=0. A reset asserted mid-request abandons the request; the memory tolerates the req drop.
- Redirect priority: trap_taken_in > mret_in > branch_taken_in. Target is trap_address_in with bits[1:0] forced to 0, or epc_in, or branch_target_in with bit0 forced to 0.
- Redirect beats stall_in. Redirect inputs are sampled in every state; upstream qualifies them.
- Next sequential PC is pc_out+4, modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
- Registered outputs only; one request in flight; no prefetch.
- State IDLE: entered only from reset. Next cycle goes to REQ with fetch_addr=BOOT_ADDRESS.
- State REQ: imem_req_out=1, imem_addr_out=fetch_addr.
  - ack, no redirect: instr_out<=imem_rdata_in, pc_out<=fetch_addr, instr_valid_out<=1; go to VALID. instr_valid_out rises the cycle after ack, and req drops at the same edge.
  - ack with redirect: discard data; stay in REQ with fetch_addr<=target (req stays high, new address).
  - redirect, no ack: pending<=target; go to KILL.
- State KILL: imem_req_out=1 with the old address held until ack.
  - A further redirect overwrites pending (latest wins).
  - On ack, data is discarded and instr_valid_out stays 0. Go to REQ with fetch_addr<=pending, or to the newest redirect target if one arrives in the ack cycle.
- State VALID: instr_valid_out=1, imem_req_out=0.
  - redirect: instr_valid_out<=0, instr_out<=NOP_INSTR; go to REQ with target.
  - stall_in=1, no redirect: all outputs held.
  - stall_in=0: instruction consumed; instr_valid_out<=0; go to REQ with fetch_addr=pc_out+4.
- Misalignment: any redirect target with bit1=1 (after forcing bit0=0) goes to MISALIGN instead of REQ/KILL. On entry pc_out<=target, instr_valid_out=0, misaligned_instr_out=1, no request issued. If this happens in REQ without ack, the outstanding request is still completed and discarded first (KILL); MISALIGN is then entered.
- State MISALIGN: only trap_taken_in exits it, clearing misaligned_instr_out and going to REQ at the trap address. mret_in and branch_taken_in are ignored.
- Sequential pc_out+4 is always aligned and never raises misaligned_instr_out.

Test Plan:
1. Reset release (BOOT_ADDRESS=0) -> req=1 with addr 0x0 one cycle after IDLE. Ack with 0x00500093 after 2 wait cycles -> next cycle valid=1, pc_out=0x0, instr_out=0x00500093, req=0.
2. In VALID at pc 0x0, stall_in=1 for 3 cycles -> outputs unchanged, req=0. stall_in=0 -> next cycle valid=0, req=1, addr=0x4.
3. In VALID at pc 0x10, branch_taken_in=1, target 0x100, with stall_in=1 -> valid=0, req to 0x100. JALR target 0x101 -> fetches 0x100, misaligned=0.
4. Request to 0x14 outstanding; branch to 0x200, then trap to 0x80 before ack -> req stays at 0x14 until ack, data discarded, valid stays 0, then req to 0x80.
5. Branch target 0x102 in VALID -> no req, misaligned=1, pc_out=0x102. mret_in ignored. trap_taken_in with 0x83 -> req to 0x80, misaligned=0.
6. Wrap/priority: consume instruction at 0xFFFF_FFFC -> req 0x0. Trap 0x80, mret epc 0x50 and branch 0x40 in the same cycle -> req 0x80. Assert reset during KILL -> req=0, valid=0 immediately, restart at BOOT_ADDRESS.
